mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Memory-stage unit and responder side of the exe/exe_mem memory interface (mem_op/mem_addr/mem_data/mem_we). It decodes the 4-bit mem op and runs a req/gnt/rsp transaction on the data-RAM bus: byte-lane strobes, store-data replication, and load extraction with sign or zero extension. It holds the pipeline through pipe_ctrl while a transaction is outstanding and registers the write-back result for the mem_wb stage.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT before a transaction is aborted with error (range 2..255)
TIMEOUT_EN, 1, 1 = timeout enabled; 0 = wait forever

Ports:
clk_in  in  1  clock
reset_n_in  in  1  asynchronous active-low reset
in_valid_in  in  1  exe_mem holds a valid instruction
mem_op_in  in  4  `MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW
mem_addr_in  in  `ADDR_WIDTH  byte address
mem_data_in  in  `DATA_WIDTH  store data (low bits significant)
reg_waddr_in  in  `RADDR_WIDTH  rd
reg_wdata_in  in  `RDATA_WIDTH  ALU result for non-memory ops
reg_we_in  in  1  rd write enable
bus_req_out  out  1  request
bus_we_out  out  1  1 = store
bus_addr_out  out  `ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
bus_be_out  out  4  byte enables
bus_wdata_out  out  `DATA_WIDTH  lane-replicated store data
bus_gnt_in  in  1  request accepted
bus_rsp_valid_in  in  1  response/ack
bus_rsp_err_in  in  1  error, qualified by rsp_valid
bus_rdata_in  in  `DATA_WIDTH  load data
stall_out  out  1  to pipe_ctrl: freeze exe_mem and earlier stages
wb_valid_out  out  1  registered result valid
wb_reg_waddr_out  out  `RADDR_WIDTH  rd
wb_reg_wdata_out  out  `RDATA_WIDTH  write-back data
wb_reg_we_out  out  1  write enable
wb_err_out  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout

Behaviour:
- Reset (async, reset_n_in=0): state IDLE, counter 0, all outputs 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, in_valid=0: wb_valid=0 next cycle.
- IDLE, valid NOP or unknown op: the next edge registers wb_valid=1, waddr/wdata/we passed through, err 0. stall_out=0. Latency is 1.
- IDLE, valid, misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus access; next edge wb_valid=1, we=0, err=1. stall_out=0.
- IDLE, valid, aligned memory op: stall_out=1 combinationally. Capture op, addr, be, wdata, rd and we. Go to REQ.
- REQ: bus_req=1 with the captured fields, held stable until gnt. On gnt, go to WAIT; gnt and rsp_valid in the same cycle count as gnt only. stall_out=1.
- WAIT: bus_req=0. stall_out=1 until rsp_valid.
  - In the rsp_valid cycle, stall_out=0 combinationally, so upstream advances on that edge.
  - On that edge: register the result and return to IDLE.
  - Load: wdata = extracted data, we = captured we.
  - Store: we=0.
  - rsp_err=1: we=0, err=2.
- Timeout (TIMEOUT_EN=1): counter clears on entry to REQ and increments each REQ/WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without completion, stall_out drops that cycle.
  - Next edge: wb_valid=1, we=0, err=3, state IDLE, bus_req deasserted.
  - A late rsp_valid arriving in IDLE is ignored.
- Store lanes, off=addr[1:0]:
  - SB: be=4'b0001<<off, wdata={4{d[7:0]}}.
  - SH: be = off[1] ? 4'b1100 : 4'b0011, wdata={2{d[15:0]}}.
  - SW: be=4'b1111, wdata=d.
- Loads: bus_be=4'b1111.
  - LB/LBU take rdata[8*off+7 -: 8], sign- or zero-extended to 32 bits.
  - LH/LHU take rdata[16*off[1]+15 -: 16], sign- or zero-extended.
  - LW takes rdata unmodified.
- A load or store to rd=0 still performs the bus access; wb_reg_we follows reg_we_in.
- wb_valid is a single-cycle pulse per accepted instruction and is never asserted twice for one instruction.
- Reset mid-transaction: returns to IDLE immediately and drops bus_req. The bus responder is reset by the same signal.

Decomposition:
- defines.v: MEM_NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; MEM_ERR_NONE/MISALIGN/BUS/TIMEOUT; MEM_ST_IDLE/REQ/WAIT.
- Sub-module mem_lane_align (combinational): op + offset + store data give be/wdata/misaligned; op + offset + rdata give load result. It is shared later with the ifetch/uncached path.

Test Plan:
- LB at addr 0x103, rdata=0x80FF_1234 -> bus_addr=0x100, be=4'b1111; wdata=0xFFFF_FF80, we=1, err=0; stall high for exactly 2 cycles with gnt in cycle 1 and rsp in cycle 2.
- SH data 0x0000_ABCD at addr 0x202 -> be=4'b1100, wdata=0xABCD_ABCD, bus_we=1; wb we=0. Repeat with gnt held low 3 cycles: req stays high and addr/be stay stable.
- LHU at 0x201 -> no bus_req, wb_valid next cycle, err=1, we=0, stall never asserted.
- Back-to-back LW 0x10 (rdata 0xDEADBEEF) then ADD result 0x5 to rd 7 -> LW writeback first, ADD next; each wb_valid a single pulse.
- TIMEOUT_CYCLES=4, gnt given, rsp never arrives -> stall drops on cycle 4, err=3, we=0; a late rsp_valid is ignored.
- reset_n_in asserted during WAIT -> bus_req, stall and wb_* all 0 immediately. After release, an LBU at 0x3 with rdata=0xFF00_0000 gives 0x0000_00FF.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Purpose  : Shared widths, memory op codes, error codes and FSM states for
//            the memory-stage access controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [1:0] MEM_ERR_NONE     = 2'd0;
  localparam logic [1:0] MEM_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] MEM_ERR_BUS      = 2'd2;
  localparam logic [1:0] MEM_ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_WAIT = 2'd2
  } mem_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : Data-RAM req/gnt/rsp bus. master = access controller,
//            slave = memory responder.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rsp_valid, rsp_err, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rsp_valid, rsp_err, rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Byte-lane steering. Store side: byte enables, replicated write
//            data and misalignment flag. Load side: lane extraction with
//            sign/zero extension. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [3:0]            op,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{off, 3'b000} +: 8];
  assign rhalf = rdata[{off[1], 4'b0000} +: 16];

  // Decode op into lane strobes, store replication and load extension
  always_comb begin
    be         = 4'b0000;
    wdata      = '0;
    misaligned = 1'b0;
    load_data  = '0;
    case (op)
      MEM_LB: begin
        be        = 4'b1111;
        load_data = {{24{rbyte[7]}}, rbyte};
      end
      MEM_LBU: begin
        be        = 4'b1111;
        load_data = {24'd0, rbyte};
      end
      MEM_LH: begin
        be         = 4'b1111;
        misaligned = off[0];
        load_data  = {{16{rhalf[15]}}, rhalf};
      end
      MEM_LHU: begin
        be         = 4'b1111;
        misaligned = off[0];
        load_data  = {16'd0, rhalf};
      end
      MEM_LW: begin
        be         = 4'b1111;
        misaligned = (off != 2'b00);
        load_data  = rdata;
      end
      MEM_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
      end
      MEM_SH: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        misaligned = off[0];
        wdata      = {2{st_data[15:0]}};
      end
      MEM_SW: begin
        be         = 4'b1111;
        misaligned = (off != 2'b00);
        wdata      = st_data;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Memory-stage controller. Runs one req/gnt/rsp data-RAM access
//            per memory op, stalls the pipeline while it is outstanding and
//            registers the write-back result for mem_wb.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit TIMEOUT_EN     = 1'b1
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic                   in_valid_in,
  input  logic [3:0]             mem_op_in,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_in,
  input  logic [DATA_WIDTH-1:0]  mem_data_in,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_in,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_in,
  input  logic                   reg_we_in,
  mem_access_ctrl_if.master      bus,
  output logic                   stall_out,
  output logic                   wb_valid_out,
  output logic [RADDR_WIDTH-1:0] wb_reg_waddr_out,
  output logic [RDATA_WIDTH-1:0] wb_reg_wdata_out,
  output logic                   wb_reg_we_out,
  output logic [1:0]             wb_err_out
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic [3:0]             cap_op, cap_op_nxt;
  logic [ADDR_WIDTH-1:0]  cap_addr, cap_addr_nxt;
  logic [3:0]             cap_be, cap_be_nxt;
  logic [DATA_WIDTH-1:0]  cap_wdata, cap_wdata_nxt;
  logic [RADDR_WIDTH-1:0] cap_rd, cap_rd_nxt;
  logic                   cap_we, cap_we_nxt;

  logic                   wb_valid_nxt, wb_we_nxt;
  logic [RADDR_WIDTH-1:0] wb_waddr_nxt;
  logic [RDATA_WIDTH-1:0] wb_wdata_nxt;
  logic [1:0]             wb_err_nxt;

  logic [3:0]            ln_op;
  logic [1:0]            ln_off;
  logic [3:0]            ln_be;
  logic [DATA_WIDTH-1:0] ln_wdata, ln_load;
  logic                  ln_misaligned;
  logic                  op_is_mem, timeout_hit;

  // In IDLE the aligner decodes the incoming op; afterwards it extracts
  // load data for the captured op, so one instance serves both directions.
  assign ln_op  = (state == MEM_ST_IDLE) ? mem_op_in : cap_op;
  assign ln_off = (state == MEM_ST_IDLE) ? mem_addr_in[1:0] : cap_addr[1:0];

  mem_lane_align u_lane_align (
    .op         (ln_op),
    .off        (ln_off),
    .st_data    (mem_data_in),
    .rdata      (bus.rdata),
    .be         (ln_be),
    .wdata      (ln_wdata),
    .misaligned (ln_misaligned),
    .load_data  (ln_load)
  );

  assign op_is_mem   = is_load(mem_op_in) || is_store(mem_op_in);
  assign timeout_hit = TIMEOUT_EN && (cnt == TMO_LAST);

  assign bus.req   = (state == MEM_ST_REQ);
  assign bus.we    = (state == MEM_ST_REQ) && is_store(cap_op);
  assign bus.addr  = {cap_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.be    = cap_be;
  assign bus.wdata = cap_wdata;

  // FSM state register
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= MEM_ST_IDLE;
    else             state <= state_nxt;
  end

  // Next state, stall, capture and write-back result selection
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cap_op_nxt    = cap_op;
    cap_addr_nxt  = cap_addr;
    cap_be_nxt    = cap_be;
    cap_wdata_nxt = cap_wdata;
    cap_rd_nxt    = cap_rd;
    cap_we_nxt    = cap_we;
    wb_valid_nxt  = 1'b0;
    wb_waddr_nxt  = wb_reg_waddr_out;
    wb_wdata_nxt  = wb_reg_wdata_out;
    wb_we_nxt     = wb_reg_we_out;
    wb_err_nxt    = wb_err_out;
    stall_out     = 1'b0;
    case (state)
      MEM_ST_IDLE: begin
        if (in_valid_in) begin
          if (!op_is_mem) begin
            wb_valid_nxt = 1'b1;
            wb_waddr_nxt = reg_waddr_in;
            wb_wdata_nxt = reg_wdata_in;
            wb_we_nxt    = reg_we_in;
            wb_err_nxt   = MEM_ERR_NONE;
          end else if (ln_misaligned) begin
            wb_valid_nxt = 1'b1;
            wb_waddr_nxt = reg_waddr_in;
            wb_wdata_nxt = '0;
            wb_we_nxt    = 1'b0;
            wb_err_nxt   = MEM_ERR_MISALIGN;
          end else begin
            stall_out     = 1'b1;
            cap_op_nxt    = mem_op_in;
            cap_addr_nxt  = mem_addr_in;
            cap_be_nxt    = ln_be;
            cap_wdata_nxt = ln_wdata;
            cap_rd_nxt    = reg_waddr_in;
            cap_we_nxt    = reg_we_in;
            cnt_nxt       = '0;
            state_nxt     = MEM_ST_REQ;
          end
        end
      end
      MEM_ST_REQ: begin
        stall_out = 1'b1;
        cnt_nxt   = cnt + 8'd1;
        if (timeout_hit) begin
          stall_out    = 1'b0;
          state_nxt    = MEM_ST_IDLE;
          wb_valid_nxt = 1'b1;
          wb_waddr_nxt = cap_rd;
          wb_wdata_nxt = '0;
          wb_we_nxt    = 1'b0;
          wb_err_nxt   = MEM_ERR_TIMEOUT;
        end else if (bus.gnt) begin
          state_nxt = MEM_ST_WAIT;
        end
      end
      MEM_ST_WAIT: begin
        stall_out = 1'b1;
        cnt_nxt   = cnt + 8'd1;
        // A response in the timeout cycle still completes normally.
        if (bus.rsp_valid) begin
          stall_out    = 1'b0;
          state_nxt    = MEM_ST_IDLE;
          wb_valid_nxt = 1'b1;
          wb_waddr_nxt = cap_rd;
          if (bus.rsp_err) begin
            wb_wdata_nxt = '0;
            wb_we_nxt    = 1'b0;
            wb_err_nxt   = MEM_ERR_BUS;
          end else if (is_load(cap_op)) begin
            wb_wdata_nxt = ln_load;
            wb_we_nxt    = cap_we;
            wb_err_nxt   = MEM_ERR_NONE;
          end else begin
            wb_wdata_nxt = '0;
            wb_we_nxt    = 1'b0;
            wb_err_nxt   = MEM_ERR_NONE;
          end
        end else if (timeout_hit) begin
          stall_out    = 1'b0;
          state_nxt    = MEM_ST_IDLE;
          wb_valid_nxt = 1'b1;
          wb_waddr_nxt = cap_rd;
          wb_wdata_nxt = '0;
          wb_we_nxt    = 1'b0;
          wb_err_nxt   = MEM_ERR_TIMEOUT;
        end
      end
      default: begin
        state_nxt = MEM_ST_IDLE;
      end
    endcase
  end

  // Captured transaction fields, timeout counter and write-back registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cnt              <= '0;
      cap_op           <= MEM_NOP;
      cap_addr         <= '0;
      cap_be           <= '0;
      cap_wdata        <= '0;
      cap_rd           <= '0;
      cap_we           <= 1'b0;
      wb_valid_out     <= 1'b0;
      wb_reg_waddr_out <= '0;
      wb_reg_wdata_out <= '0;
      wb_reg_we_out    <= 1'b0;
      wb_err_out       <= MEM_ERR_NONE;
    end else begin
      cnt              <= cnt_nxt;
      cap_op           <= cap_op_nxt;
      cap_addr         <= cap_addr_nxt;
      cap_be           <= cap_be_nxt;
      cap_wdata        <= cap_wdata_nxt;
      cap_rd           <= cap_rd_nxt;
      cap_we           <= cap_we_nxt;
      wb_valid_out     <= wb_valid_nxt;
      wb_reg_waddr_out <= wb_waddr_nxt;
      wb_reg_wdata_out <= wb_wdata_nxt;
      wb_reg_we_out    <= wb_we_nxt;
      wb_err_out       <= wb_err_nxt;
    end
  end

endmodule
`default_nettype wire
